dram_busif: RTL and testbench

DRAM_BUSIF -- requirements
Module: dram_busif

---
 rtl/dram_pkg.sv | 22 ++
 rtl/dram_be_decode.sv | 19 +
 rtl/dram_busif.sv | 107 ++++++++++
 tb/tb_dram_busif.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared encodings for the 68040-to-DRAM bus interface: FSM states,
// 68040 SIZ/TT codes and the line burst length.
package dram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_TACK = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;

  localparam logic [1:0] TT_NORMAL = 2'b00;
  localparam logic [1:0] TT_MOVE16 = 2'b01;

  localparam int LINE_BEATS = 4;

endpackage

// File: rtl/dram_be_decode.sv
// Big-endian byte-lane decode from 68040 SIZ and A[1:0]; bit 3 is D[31:24].
module dram_be_decode
  import dram_pkg::*;
(
  input  logic [1:0] i_siz,
  input  logic [1:0] i_addrLo,
  output logic [3:0] o_be
);

  always_comb begin
    o_be = 4'b1111;
    unique case (i_siz)
      SIZ_BYTE: o_be = 4'b1000 >> i_addrLo;
      SIZ_WORD: o_be = i_addrLo[1] ? 4'b0011 : 4'b1100;
      default:  o_be = 4'b1111;
    endcase
  end

endmodule

// File: rtl/dram_busif.sv
// 68040 bus slave that turns CPU transfers into DRAM beat requests.
// Define DRAM_BURST_EN to run line transfers as 4-beat bursts instead of inhibiting them.
module dram_busif
  import dram_pkg::*;
#(
  parameter logic [3:0] BASE_NIB  = 4'h0,
  parameter int         INST_BITS = 26
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        TS_n,
  input  logic [31:0] A,
  input  logic        RW,
  input  logic [1:0]  SIZ,
  input  logic [1:0]  TT,
  output logic        TA_n,
  output logic        TEA_n,
  output logic        TBI_n,
  output logic        req,
  output logic        req_rw,
  output logic [25:0] req_addr,
  output logic [3:0]  req_be,
  output logic        req_last,
  input  logic        beat_ack
);

`ifdef DRAM_BURST_EN
  localparam logic BURST_EN = 1'b1;
`else
  localparam logic BURST_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_next;
  logic        w_hit;
  logic        w_rangeErr;
  logic        w_isLine;
  logic [3:0]  w_be;
  logic        r_rw;
  logic [25:0] r_addr;
  logic [3:0]  r_be;
  logic        r_last;
  logic        r_isLine;
  logic [1:0]  r_beatCnt;

  dram_be_decode u_beDecode (
    .i_siz    (SIZ),
    .i_addrLo (A[1:0]),
    .o_be     (w_be)
  );

  assign w_hit      = !TS_n && (A[31:28] == BASE_NIB) &&
                      ((TT == TT_NORMAL) || (TT == TT_MOVE16));
  // Any address bit between the installed size and the select nibble is an error.
  assign w_rangeErr = (A[27:0] >> INST_BITS) != 28'd0;
  assign w_isLine   = (SIZ == SIZ_LINE);

  always_ff @(posedge clk) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_hit) w_next = w_rangeErr ? S_ERR : S_REQ;
      S_REQ:   if (beat_ack) w_next = S_TACK;
      S_TACK:  w_next = r_last ? S_IDLE : S_REQ;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are captured only for transfers that will actually be served.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_be      <= '0;
      r_last    <= 1'b0;
      r_isLine  <= 1'b0;
      r_beatCnt <= '0;
    end else if (r_state == S_IDLE && w_hit && !w_rangeErr) begin
      r_rw      <= RW;
      r_addr    <= A[27:2];
      r_be      <= w_be;
      r_last    <= !(BURST_EN && w_isLine);
      r_isLine  <= w_isLine;
      r_beatCnt <= '0;
    end else if (r_state == S_TACK && !r_last) begin
      r_addr[1:0] <= r_addr[1:0] + 2'd1;
      r_beatCnt   <= r_beatCnt + 2'd1;
      r_last      <= (r_beatCnt == 2'(LINE_BEATS - 2));
    end
  end

  assign req      = (r_state == S_REQ);
  assign TA_n     = !(r_state == S_TACK);
  assign TEA_n    = !(r_state == S_ERR);
  // Without bursting, a line is acked once with TBI_n so the CPU re-issues it as longs.
  assign TBI_n    = !(r_state == S_TACK && r_isLine && !BURST_EN);
  assign req_rw   = r_rw;
  assign req_addr = r_addr;
  assign req_be   = r_be;
  assign req_last = r_last;

endmodule

// File: tb/tb_dram_busif.sv
// Directed plus randomized checks of dram_busif against a transfer-level model;
// follows DRAM_BURST_EN to choose the expected line behaviour.
module tb_dram_busif;

`ifdef DRAM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        TS_n = 1'b1;
  logic [31:0] A = '0;
  logic        RW = 1'b1;
  logic [1:0]  SIZ = '0;
  logic [1:0]  TT = '0;
  logic        TA_n, TEA_n, TBI_n, req, req_rw, req_last;
  logic [25:0] req_addr;
  logic [3:0]  req_be;
  logic        beat_ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  dram_busif dut (
    .clk      (clk),
    .RESET    (RESET),
    .TS_n     (TS_n),
    .A        (A),
    .RW       (RW),
    .SIZ      (SIZ),
    .TT       (TT),
    .TA_n     (TA_n),
    .TEA_n    (TEA_n),
    .TBI_n    (TBI_n),
    .req      (req),
    .req_rw   (req_rw),
    .req_addr (req_addr),
    .req_be   (req_be),
    .req_last (req_last),
    .beat_ack (beat_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Byte lanes from the 68040 size rules, big-endian.
  function automatic logic [3:0] expBe(input logic [1:0] siz, input logic [1:0] lo);
    int bytes;
    int first;
    bytes = (siz == 2'b01) ? 1 : (siz == 2'b10) ? 2 : 4;
    first = (bytes == 4) ? 0 : (bytes == 2) ? int'(lo[1]) * 2 : int'(lo);
    expBe = '0;
    for (int k = 0; k < bytes; k++) expBe[3 - first - k] = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req"}, 32'(req), 32'd0);
    checkOutput({tag, "_ta"}, 32'(TA_n), 32'd1);
    checkOutput({tag, "_tea"}, 32'(TEA_n), 32'd1);
    checkOutput({tag, "_tbi"}, 32'(TBI_n), 32'd1);
  endtask

  task automatic checkResetOutputs();
    checkIdleOutputs("rst");
    checkOutput("rst_rw", 32'(req_rw), 32'd1);
    checkOutput("rst_addr", 32'(req_addr), 32'd0);
    checkOutput("rst_be", 32'(req_be), 32'd0);
    checkOutput("rst_last", 32'(req_last), 32'd0);
  endtask

  // One complete CPU transfer, with expectations derived from the bus rules.
  task automatic applyStimulus(input logic [31:0] addr, input logic rw,
                               input logic [1:0] siz, input logic [1:0] tt);
    bit          hit;
    bit          err;
    bit          line;
    int          beats;
    int          waitCycles;
    logic [25:0] expAddr;
    logic [1:0]  lo;
    hit   = (addr[31:28] == 4'h0) && (tt == 2'b00 || tt == 2'b01);
    err   = hit && (addr[27:26] != 2'b00);
    line  = (siz == 2'b11);
    beats = (line && BURST) ? 4 : 1;
    TS_n = 1'b0; A = addr; RW = rw; SIZ = siz; TT = tt;
    tick();
    TS_n = 1'b1; A = $urandom; RW = 1'($urandom); SIZ = 2'($urandom); TT = 2'($urandom);
    if (!hit) begin
      repeat (2) begin
        checkIdleOutputs("ignore");
        tick();
      end
    end else if (err) begin
      checkOutput("err_tea", 32'(TEA_n), 32'd0);
      checkOutput("err_ta", 32'(TA_n), 32'd1);
      checkOutput("err_req", 32'(req), 32'd0);
      tick();
      checkIdleOutputs("err_after");
    end else begin
      for (int b = 0; b < beats; b++) begin
        lo = 2'((int'(addr[3:2]) + b) % 4);
        expAddr = {addr[27:4], lo};
        checkOutput("beat_req", 32'(req), 32'd1);
        checkOutput("beat_addr", 32'(req_addr), 32'(expAddr));
        checkOutput("beat_be", 32'(req_be), 32'(expBe(siz, addr[1:0])));
        checkOutput("beat_last", 32'(req_last), 32'(b == beats - 1));
        checkOutput("beat_rw", 32'(req_rw), 32'(rw));
        checkOutput("beat_ta_wait", 32'(TA_n), 32'd1);
        waitCycles = $urandom_range(0, 2);
        repeat (waitCycles) begin
          if ($urandom_range(0, 1) == 1) begin
            TS_n = 1'b0; A = 32'h0000_0100; TT = 2'b00;
          end
          tick();
          TS_n = 1'b1;
          checkOutput("hold_req", 32'(req), 32'd1);
          checkOutput("hold_addr", 32'(req_addr), 32'(expAddr));
        end
        beat_ack = 1'b1;
        tick();
        beat_ack = 1'b0;
        checkOutput("ack_req", 32'(req), 32'd0);
        checkOutput("ack_ta", 32'(TA_n), 32'd0);
        checkOutput("ack_tea", 32'(TEA_n), 32'd1);
        checkOutput("ack_tbi", 32'(TBI_n), 32'(!(line && !BURST)));
        tick();
      end
      checkIdleOutputs("done");
    end
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] addr;
    logic [1:0]  tt;
    $display("[TB] start, burst=%0d", BURST);
    tick();
    tick();
    checkResetOutputs();
    RESET = 1'b0;
    tick();

    applyStimulus(32'h0000_1004, 1'b1, 2'b00, 2'b00);
    applyStimulus(32'h0000_2008, 1'b1, 2'b11, 2'b00);
    applyStimulus(32'h0000_0003, 1'b0, 2'b01, 2'b00);
    applyStimulus(32'h0000_0002, 1'b0, 2'b10, 2'b01);
    applyStimulus(32'h0C00_0000, 1'b1, 2'b00, 2'b00);
    applyStimulus(32'h1000_0000, 1'b1, 2'b00, 2'b00);
    applyStimulus(32'h0000_0000, 1'b1, 2'b00, 2'b11);

    beat_ack = 1'b1;
    tick();
    beat_ack = 1'b0;
    checkIdleOutputs("stray_ack");

    // Reset while a line transfer is in flight.
    TS_n = 1'b0; A = 32'h0000_2008; RW = 1'b1; SIZ = 2'b11; TT = 2'b00;
    tick();
    TS_n = 1'b1;
    if (BURST) begin
      beat_ack = 1'b1;
      tick();
      beat_ack = 1'b0;
      tick();
    end
    checkOutput("mid_req", 32'(req), 32'd1);
    checkOutput("mid_addr", 32'(req_addr[1:0]), BURST ? 32'd3 : 32'd2);
    RESET = 1'b1;
    beat_ack = 1'b1;
    tick();
    RESET = 1'b0;
    beat_ack = 1'b0;
    checkResetOutputs();
    tick();
    checkIdleOutputs("post_rst");
    applyStimulus(32'h0000_1004, 1'b1, 2'b00, 2'b00);

    // Reset beats a coincident transfer start.
    RESET = 1'b1; TS_n = 1'b0; A = 32'h0000_0040; TT = 2'b00;
    tick();
    RESET = 1'b0; TS_n = 1'b1;
    checkResetOutputs();
    tick();
    checkIdleOutputs("rst_ts");

    for (int n = 0; n < 40; n++) begin
      rnd  = $urandom;
      addr = {4'h0, 2'b00, rnd[25:0]};
      if ($urandom_range(0, 4) == 0) addr[31:28] = 4'(1 + $urandom_range(0, 14));
      if ($urandom_range(0, 5) == 0) addr[27:26] = 2'(1 + $urandom_range(0, 2));
      tt = ($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      applyStimulus(addr, 1'($urandom), 2'($urandom), tt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
